// File: rtl/alu_result_collector.sv
// First-word-fall-through collector for 6-bit signed ALU results ([0:5], bit 0 = MSB).
// Define ALU_RES_ACC_EN to add the saturating 10-bit running sum output `acc`.
module alu_result_collector #(
    parameter int DEPTH = 4  // power of two, 2..16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     C_en,
    input  logic [0:5]               C,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [0:5]               out_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic                     drop_err,
    input  logic                     clr_err
`ifdef ALU_RES_ACC_EN
    ,
    output logic [9:0]               acc
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [0:5]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push;
    logic          pop;
    logic          drop;

    assign full      = (count == DEPTH_C);
    assign empty     = (count == '0);
    assign out_valid = !empty;
    assign out_data  = empty ? 6'b0 : mem[rd_ptr];

    // Handshake: the head entry transfers on any edge where out_valid && out_ready;
    // out_ready is ignored while out_valid is low. A pop frees a slot for a push
    // on the same edge, so a full buffer with out_ready high never drops.
    assign pop  = out_valid && out_ready;
    assign push = C_en && (!full || pop);
    assign drop = C_en && full && !pop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            drop_err <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= C;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            // A drop on the same edge as a clear keeps the flag set.
            if (drop) begin
                drop_err <= 1'b1;
            end else if (clr_err) begin
                drop_err <= 1'b0;
            end
        end
    end

`ifdef ALU_RES_ACC_EN
    logic signed [10:0] acc_sum;

    assign acc_sum = $signed({acc[9], acc}) + $signed({{5{C[0]}}, C});

    // Only accepted results are summed; the sum clamps to [-512, 511] and holds there.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
        end else if (push) begin
            if (acc_sum > 11'sd511) begin
                acc <= 10'h1FF;
            end else if (acc_sum < -11'sd512) begin
                acc <= 10'h200;
            end else begin
                acc <= acc_sum[9:0];
            end
        end
    end
`endif

endmodule

// File: tb/tb_alu_result_collector.sv
// Directed bench for alu_result_collector (DEPTH = 4); acc checks are
// included when ALU_RES_ACC_EN is defined.
module tb_alu_result_collector;

    logic       clk;
    logic       rst;
    logic       C_en;
    logic [0:5] C;
    logic       out_valid;
    logic       out_ready;
    logic [0:5] out_data;
    logic [2:0] count;
    logic       full;
    logic       empty;
    logic       drop_err;
    logic       clr_err;
`ifdef ALU_RES_ACC_EN
    logic [9:0] acc;
`endif

    int compared   = 0;
    int mismatched = 0;

    alu_result_collector #(.DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .C_en      (C_en),
        .C         (C),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .drop_err  (drop_err),
        .clr_err   (clr_err)
`ifdef ALU_RES_ACC_EN
        ,
        .acc       (acc)
`endif
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [5:0] s6(input int v);
        return 6'(v);
    endfunction

    function automatic logic [9:0] s10(input int v);
        return 10'(v);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Driver: apply inputs, then advance one edge and settle before checking.
    task automatic step(input logic en, input logic [5:0] c, input logic rdy, input logic clr);
        C_en      = en;
        C         = c;
        out_ready = rdy;
        clr_err   = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        C_en      = 1'b0;
        C         = 'x;
        out_ready = 1'b0;
        clr_err   = 1'b0;
    endtask

    initial begin
        int stream [10] = '{1, -2, 3, -4, 5, -6, 7, -8, 9, -10};

        rst = 1'b1;
        idle();
        #2;
        chk("rst_count",    32'(count),     32'd0);
        chk("rst_empty",    32'(empty),     32'd1);
        chk("rst_full",     32'(full),      32'd0);
        chk("rst_valid",    32'(out_valid), 32'd0);
        chk("rst_data",     32'(out_data),  32'd0);
        chk("rst_drop_err", 32'(drop_err),  32'd0);
`ifdef ALU_RES_ACC_EN
        chk("rst_acc",      32'(acc),       32'd0);
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Fill: -32, 31, 0, -1 with no consumer; first result visible after one edge.
        step(1'b1, s6(-32), 1'b0, 1'b0);
        chk("fill1_valid", 32'(out_valid), 32'd1);
        chk("fill1_data",  32'(out_data),  32'(s6(-32)));
        chk("fill1_count", 32'(count),     32'd1);
        step(1'b1, s6(31), 1'b0, 1'b0);
        step(1'b1, s6(0),  1'b0, 1'b0);
        step(1'b1, s6(-1), 1'b0, 1'b0);
        chk("fill4_count",    32'(count),    32'd4);
        chk("fill4_full",     32'(full),     32'd1);
        chk("fill4_data",     32'(out_data), 32'(s6(-32)));
        chk("fill4_drop_err", 32'(drop_err), 32'd0);
`ifdef ALU_RES_ACC_EN
        chk("fill4_acc",      32'(acc),      32'(s10(-2)));
`endif

        // Push into a full buffer with no pop: discarded, sticky error.
        step(1'b1, s6(5), 1'b0, 1'b0);
        chk("drop_count",    32'(count),    32'd4);
        chk("drop_err_set",  32'(drop_err), 32'd1);
        chk("drop_head",     32'(out_data), 32'(s6(-32)));
`ifdef ALU_RES_ACC_EN
        chk("drop_acc",      32'(acc),      32'(s10(-2)));
`endif
        step(1'b0, s6(0), 1'b0, 1'b1);
        chk("clr_err",       32'(drop_err), 32'd0);
        // Drop and clear on the same edge: drop wins.
        step(1'b1, s6(5), 1'b0, 1'b1);
        chk("drop_beats_clr", 32'(drop_err), 32'd1);
        step(1'b0, s6(0), 1'b0, 1'b1);
        chk("clr_err2",      32'(drop_err), 32'd0);

        // Full with simultaneous pop and push of 7.
        step(1'b1, s6(7), 1'b1, 1'b0);
        chk("pp_full_count", 32'(count),    32'd4);
        chk("pp_full_drop",  32'(drop_err), 32'd0);
        chk("pp_full_head",  32'(out_data), 32'(s6(31)));
`ifdef ALU_RES_ACC_EN
        chk("pp_full_acc",   32'(acc),      32'(s10(5)));
`endif

        // Drain in order: 31, 0, -1, 7.
        chk("drain0", 32'(out_data), 32'(s6(31)));
        step(1'b0, s6(0), 1'b1, 1'b0);
        chk("drain1", 32'(out_data), 32'(s6(0)));
        step(1'b0, s6(0), 1'b1, 1'b0);
        chk("drain2", 32'(out_data), 32'(s6(-1)));
        step(1'b0, s6(0), 1'b1, 1'b0);
        chk("drain3", 32'(out_data), 32'(s6(7)));
        step(1'b0, s6(0), 1'b1, 1'b0);
        chk("drained_empty", 32'(empty),    32'd1);
        chk("drained_data",  32'(out_data), 32'd0);
        // Pop on empty is ignored; X on C with C_en low is ignored.
        step(1'b0, 6'bxxxxxx, 1'b1, 1'b0);
        chk("pop_empty_count", 32'(count), 32'd0);
        chk("x_ignored_valid", 32'(out_valid), 32'd0);

        // Stream 10 with the consumer always ready: count stays at 1.
        for (int i = 0; i < 10; i++) begin
            step(1'b1, s6(stream[i]), 1'b1, 1'b0);
            chk($sformatf("stream%0d_data", i),  32'(out_data), 32'(s6(stream[i])));
            chk($sformatf("stream%0d_count", i), 32'(count),    32'd1);
        end
        step(1'b0, s6(0), 1'b1, 1'b0);
        chk("stream_end_empty", 32'(empty), 32'd1);

        // Reset mid-operation with three entries buffered.
        step(1'b1, s6(11), 1'b0, 1'b0);
        step(1'b1, s6(12), 1'b0, 1'b0);
        step(1'b1, s6(13), 1'b0, 1'b0);
        chk("pre_rst_count", 32'(count), 32'd3);
        #3;
        rst = 1'b1;
        #1;
        chk("async_rst_count", 32'(count),     32'd0);
        chk("async_rst_valid", 32'(out_valid), 32'd0);
        chk("async_rst_data",  32'(out_data),  32'd0);
`ifdef ALU_RES_ACC_EN
        chk("async_rst_acc",   32'(acc),       32'd0);
`endif
        step(1'b1, s6(9), 1'b1, 1'b0);
        chk("in_rst_no_push", 32'(count), 32'd0);
        rst = 1'b0;
        step(1'b1, s6(9), 1'b0, 1'b0);
        chk("post_rst_count", 32'(count),    32'd1);
        chk("post_rst_data",  32'(out_data), 32'(s6(9)));
        step(1'b0, s6(0), 1'b1, 1'b0);
        chk("post_rst_drain", 32'(empty), 32'd1);

`ifdef ALU_RES_ACC_EN
        // Saturation: 16*31 = 496, 17*31 clamps at 511 and holds.
        rst = 1'b1;
        #1;
        rst = 1'b0;
        for (int i = 0; i < 16; i++) step(1'b1, s6(31), 1'b1, 1'b0);
        chk("acc_496", 32'(acc), 32'(s10(496)));
        step(1'b1, s6(31), 1'b1, 1'b0);
        chk("acc_sat_hi", 32'(acc), 32'(s10(511)));
        step(1'b1, s6(31), 1'b1, 1'b0);
        chk("acc_hold_hi", 32'(acc), 32'(s10(511)));
        step(1'b1, s6(-32), 1'b1, 1'b0);
        chk("acc_479", 32'(acc), 32'(s10(479)));
        // 479 - 31*32 = -513 clamps to -512.
        for (int i = 0; i < 31; i++) step(1'b1, s6(-32), 1'b1, 1'b0);
        chk("acc_sat_lo", 32'(acc), 32'(s10(-512)));
        step(1'b0, s6(0), 1'b1, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/alu_result_collector.md
ALU_RESULT_COLLECTOR -- requirements
Module: alu_result_collector

Interface
REQ-001 Parameter DEPTH, default 4, result buffer entries; power of two, 2..16.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 C_en  input  1  ALU result-valid strobe, one result per asserted cycle.
REQ-005 C  input  6  ALU result, signed two's complement, bit 0 is MSB ([0:5]).
REQ-006 out_valid  output  1  head entry available.
REQ-007 out_ready  input  1  consumer accepts head entry this cycle.
REQ-008 out_data  output  6  head entry, signed, [0:5] ordering.
REQ-009 count  output  clog2(DEPTH)+1  current occupancy.
REQ-010 full  output  1  count == DEPTH.
REQ-011 empty  output  1  count == 0.
REQ-012 drop_err  output  1  sticky flag, a result was discarded.
REQ-013 clr_err  input  1  synchronous clear of drop_err.
REQ-014 acc  output  10  signed saturating sum of accepted results (ALU_RES_ACC_EN only).

Function
REQ-015 Buffer SHALL be first-word-fall-through FIFO; out_data SHALL equal head entry combinationally whenever out_valid = 1.
REQ-016 out_valid SHALL equal !empty; out_data SHALL be 0 when empty.
REQ-017 Pop SHALL occur when out_valid && out_ready; push SHALL occur when C_en && (!full || pop).
REQ-018 Latency SHALL be one cycle: a result pushed at edge N SHALL appear on out_data after edge N when buffer was empty.
REQ-019 Simultaneous push and pop SHALL leave count unchanged, including at full and at count 1.
REQ-020 Pop with empty buffer SHALL be ignored; out_ready is don't-care when out_valid = 0.
REQ-021 C_en && full && !pop SHALL discard C, leave buffer unchanged, and set drop_err on that edge.
REQ-022 clr_err SHALL clear drop_err at next edge; a drop in the same cycle SHALL win (drop_err stays 1).
REQ-023 Read and write pointers SHALL wrap modulo DEPTH with no lost or duplicated entry.
REQ-024 C SHALL be stored unmodified; sign and bit order SHALL be preserved end to end.
REQ-025 C SHALL be ignored in cycles with C_en = 0, including X values.

Reset
REQ-026 rst SHALL asynchronously force count=0, pointers=0, empty=1, full=0, out_valid=0, out_data=0, drop_err=0, acc=0.
REQ-027 Reset mid-operation SHALL discard all buffered entries; no pop or push SHALL occur in a cycle where rst is high.
REQ-028 First push after rst deasserts SHALL be accepted on the first posedge clk with rst low.

Configuration
REQ-029 Macro ALU_RES_ACC_EN SHALL compile in the acc port and accumulator register.
REQ-030 With ALU_RES_ACC_EN: each push SHALL update acc <= sat(acc + C), clamped to [-512, +511]; dropped results SHALL not be summed; acc SHALL hold at limit without wrap.
REQ-031 Without ALU_RES_ACC_EN: acc port and register SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-032 Reset then push C = -32, 31, 0, -1 on 4 cycles, out_ready=0 -> count=4, full=1, out_data=-32, drop_err=0.
REQ-033 Full buffer, C_en=1 with C=5, out_ready=0 -> C discarded, count=4, drop_err=1; then clr_err=1 -> drop_err=0.
REQ-034 Full buffer, C_en=1 with C=7 and out_ready=1 same cycle -> head popped, 7 enqueued, count=4, drop_err=0.
REQ-035 Stream 10 results with out_ready=1 every cycle -> outputs in order with 1-cycle latency, count never exceeds 1, pointers wrap twice.
REQ-036 Assert rst with count=3 mid-stream -> immediately count=0, out_valid=0, out_data=0, acc=0; next push accepted normally.
REQ-037 ALU_RES_ACC_EN defined, push +31 seventeen times -> acc=511 saturated and held; push -32 once -> acc=479.
